// File: rtl/shifter_pkg.sv
// ============================================================================
//  Module   : shifter_pkg
//  Brief    : Mode and FSM state encodings shared by the sequential shifter.
//             Optional feature macro used by this slice: SHIFTER_CARRY_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package shifter_pkg;

    localparam logic [1:0] SH_LOGICAL = 2'b00;
    localparam logic [1:0] SH_ARITH   = 2'b01;
    localparam logic [1:0] SH_ROTATE  = 2'b10;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/seq_shifter_shift_step.sv
// ============================================================================
//  Module   : shift_step
//  Brief    : Combinational shift by 0..STEP bits in one direction/mode.
//             With SHIFTER_CARRY_EN it also returns the last bit shifted out.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module shift_step
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int STEP  = 1,
    parameter int SW    = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] i_din,
    input  logic [SW-1:0]    i_s,
    input  logic             i_dir,
    input  logic [1:0]       i_mode,
    input  logic             i_fill,
    output logic [WIDTH-1:0] o_dout
`ifdef SHIFTER_CARRY_EN
    ,
    output logic             o_bit_out
`endif
);

    logic [WIDTH-1:0] w_val;
`ifdef SHIFTER_CARRY_EN
    logic             w_out;
`endif

    // i_dir = 1 shifts right; the reserved mode falls through to logical fill.
    always_comb begin
        w_val = i_din;
`ifdef SHIFTER_CARRY_EN
        w_out = 1'b0;
`endif
        for (int i = 0; i < STEP; i++) begin
            if (i < int'(i_s)) begin
`ifdef SHIFTER_CARRY_EN
                w_out = i_dir ? w_val[0] : w_val[WIDTH-1];
`endif
                if (i_dir) begin
                    w_val = {(i_mode == SH_ROTATE) ? w_val[0] :
                             (i_mode == SH_ARITH)  ? i_fill : 1'b0,
                             w_val[WIDTH-1:1]};
                end else begin
                    w_val = {w_val[WIDTH-2:0],
                             (i_mode == SH_ROTATE) ? w_val[WIDTH-1] : 1'b0};
                end
            end
        end
    end

    assign o_dout = w_val;
`ifdef SHIFTER_CARRY_EN
    assign o_bit_out = w_out;
`endif

endmodule

`default_nettype wire

// File: rtl/seq_shifter.sv
// ============================================================================
//  Module   : seq_shifter
//  Brief    : Multi-cycle signed-count shifter (logical/arith/rotate), STEP bits
//             per cycle, valid/ready on both sides. Macro: SHIFTER_CARRY_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int AMT_W = $clog2(WIDTH) + 2,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src,
    input  logic [AMT_W-1:0] amt,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    localparam int RW = $clog2(WIDTH + 1);
    localparam int SW = $clog2(STEP + 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] r_data;
    logic [RW-1:0]    r_rem;
    logic             r_dir;
    logic [1:0]       r_mode;
    logic             r_fill;

    logic [AMT_W-1:0] w_mag;
    logic [RW-1:0]    w_rem0;
    logic             w_idle;
    logic             w_accept;
    logic             w_load;
    logic [RW-1:0]    w_cur_rem;
    logic [SW-1:0]    w_s;
    logic [RW-1:0]    w_rem_next;
    logic [WIDTH-1:0] w_step_data;

    // Two's-complement negate; the most-negative count maps to 2^(AMT_W-1).
    assign w_mag = amt[AMT_W-1] ? (~amt + AMT_W'(1)) : amt;

    always_comb begin
        w_rem0 = '0;
        if (mode == SH_ROTATE) begin
            w_rem0 = RW'(w_mag % AMT_W'(WIDTH));
        end else if (w_mag >= AMT_W'(WIDTH)) begin
            w_rem0 = RW'(WIDTH);
        end else begin
            w_rem0 = RW'(w_mag);
        end
    end

    assign w_idle     = (r_state == S_IDLE);
    assign w_accept   = in_valid & in_ready;
    assign w_load     = w_accept | (r_state == S_SHIFT);

    // The first step is taken on the accept edge itself, straight from the inputs.
    assign w_cur_rem  = w_idle ? w_rem0 : r_rem;
    assign w_s        = (w_cur_rem >= RW'(STEP)) ? SW'(STEP) : SW'(w_cur_rem);
    assign w_rem_next = w_cur_rem - RW'(w_s);

`ifdef SHIFTER_CARRY_EN
    logic w_step_out;
    logic r_carry;
`endif

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .SW    (SW)
    ) u_step (
        .i_din     (w_idle ? src : r_data),
        .i_s       (w_s),
        .i_dir     (w_idle ? amt[AMT_W-1] : r_dir),
        .i_mode    (w_idle ? mode : r_mode),
        .i_fill    (w_idle ? src[WIDTH-1] : r_fill),
        .o_dout    (w_step_data)
`ifdef SHIFTER_CARRY_EN
        ,
        .o_bit_out (w_step_out)
`endif
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = (w_rem_next == '0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_rem_next == '0) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = w_idle & ~reset;
        out_valid = (r_state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data <= '0;
            r_rem  <= '0;
            r_dir  <= 1'b0;
            r_mode <= SH_LOGICAL;
            r_fill <= 1'b0;
        end else begin
            if (w_load) begin
                r_data <= w_step_data;
                r_rem  <= w_rem_next;
            end
            if (w_accept) begin
                r_dir  <= amt[AMT_W-1];
                r_mode <= mode;
                r_fill <= src[WIDTH-1];
            end
        end
    end

    assign result = r_data;

`ifdef SHIFTER_CARRY_EN
    // A zero count takes no step, so the step's bit-out is 0 on that accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_carry <= 1'b0;
        end else if (w_load) begin
            r_carry <= w_step_out;
        end
    end
    assign carry = r_carry;
`else
    assign carry = 1'b0;
`endif

endmodule

`default_nettype wire
